// File: rtl/ccsds_ec_pkg.sv
// Shared constants, codeword length clamp and FSM state type for the
// codebook encode path and its downstream bit packer.
package ccsds_ec_pkg;

    localparam int ENCODE_DATALENGTH = 21;
    localparam int CW_LEN_W          = 6;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic logic [CW_LEN_W-1:0] clamp_len(
        input logic [CW_LEN_W-1:0] len,
        input logic [CW_LEN_W-1:0] max_len
    );
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/codeword_packer.sv
// Concatenates variable-length codewords MSB-first into fixed-width words;
// a flush zero-pads the trailing partial word and tags it last.
module codeword_packer
    import ccsds_ec_pkg::*;
#(
    parameter int ENCODE_DATALENGTH = ccsds_ec_pkg::ENCODE_DATALENGTH,
    parameter int OUT_WIDTH         = 32,
    parameter int ACC_WIDTH         = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cw_valid_i,
    output logic                           cw_ready_o,
    input  logic [ENCODE_DATALENGTH-1:0]   cw_data_i,
    input  logic [CW_LEN_W-1:0]            cw_length_i,
    input  logic                           flush_i,
    output logic                           word_valid_o,
    input  logic                           word_ready_i,
    output logic [OUT_WIDTH-1:0]           word_data_o,
    output logic [$clog2(OUT_WIDTH+1)-1:0] word_nbits_o,
    output logic                           word_last_o,
    output logic                           overflow_err_o
);

    localparam int FILL_W = $clog2(ACC_WIDTH + 1);
    localparam int NB_W   = $clog2(OUT_WIDTH + 1);

    logic [ACC_WIDTH-1:0] acc_r;
    logic [FILL_W-1:0]    fill_r;
    state_e               state_r;
    logic                 cw_ready_r;
    logic                 word_valid_r;
    logic [OUT_WIDTH-1:0] word_data_r;
    logic [NB_W-1:0]      word_nbits_r;
    logic                 word_last_r;
    logic                 overflow_r;

    logic                 slot_free_s;
    logic                 emit_s;
    logic                 pad_s;
    logic                 accept_s;
    logic                 ovf_s;
    logic [CW_LEN_W-1:0]  len_s;
    logic [ACC_WIDTH-1:0] acc_emit_s;
    logic [ACC_WIDTH-1:0] cw_bits_s;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic [FILL_W-1:0]    fill_emit_s;
    logic [FILL_W-1:0]    fill_next_s;
    logic [FILL_W-1:0]    shift_s;
    state_e               state_next_s;

    // Next accumulator/fill/state: emit first, then append at the post-emit fill.
    always_comb begin
        slot_free_s = !word_valid_r || word_ready_i;
        emit_s      = (fill_r >= FILL_W'(OUT_WIDTH)) && slot_free_s;
        pad_s       = (state_r == FLUSH) && (fill_r < FILL_W'(OUT_WIDTH)) && slot_free_s;
        accept_s    = cw_valid_i && cw_ready_r;
        len_s       = clamp_len(cw_length_i, CW_LEN_W'(ENCODE_DATALENGTH));
        ovf_s       = accept_s && (cw_length_i > CW_LEN_W'(ENCODE_DATALENGTH));

        if (emit_s) begin
            acc_emit_s  = acc_r << OUT_WIDTH;
            fill_emit_s = fill_r - FILL_W'(OUT_WIDTH);
        end else begin
            acc_emit_s  = acc_r;
            fill_emit_s = fill_r;
        end

        // Bits above len are ignored, so mask before positioning.
        cw_bits_s = ACC_WIDTH'(cw_data_i) & ((ACC_WIDTH'(1'b1) << len_s) - ACC_WIDTH'(1'b1));
        shift_s   = FILL_W'(ACC_WIDTH) - fill_emit_s - FILL_W'(len_s);

        if (pad_s) begin
            acc_next_s  = '0;
            fill_next_s = '0;
        end else if (accept_s) begin
            acc_next_s  = acc_emit_s | (cw_bits_s << shift_s);
            fill_next_s = fill_emit_s + FILL_W'(len_s);
        end else begin
            acc_next_s  = acc_emit_s;
            fill_next_s = fill_emit_s;
        end

        case (state_r)
            RUN: begin
                if (flush_i) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            FLUSH: begin
                if (pad_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: state_next_s = RUN;
        endcase
    end

    // State, accumulator and output word registers; ready is precomputed from next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r        <= '0;
            fill_r       <= '0;
            state_r      <= RUN;
            cw_ready_r   <= 1'b1;
            word_valid_r <= 1'b0;
            word_data_r  <= '0;
            word_nbits_r <= '0;
            word_last_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            acc_r      <= acc_next_s;
            fill_r     <= fill_next_s;
            state_r    <= state_next_s;
            cw_ready_r <= (state_next_s == RUN) &&
                          (fill_next_s <= FILL_W'(ACC_WIDTH - ENCODE_DATALENGTH));
            overflow_r <= overflow_r || ovf_s;
            if (emit_s || pad_s) begin
                word_valid_r <= 1'b1;
                word_data_r  <= acc_r[ACC_WIDTH-1 -: OUT_WIDTH];
                word_nbits_r <= emit_s ? NB_W'(OUT_WIDTH) : fill_r[NB_W-1:0];
                word_last_r  <= pad_s;
            end else if (word_ready_i) begin
                word_valid_r <= 1'b0;
            end
        end
    end

    assign cw_ready_o     = cw_ready_r;
    assign word_valid_o   = word_valid_r;
    assign word_data_o    = word_data_r;
    assign word_nbits_o   = word_nbits_r;
    assign word_last_o    = word_last_r;
    assign overflow_err_o = overflow_r;

endmodule

// File: tb/tb_codeword_packer.sv
// Directed-vector bench for codeword_packer: packing, backpressure, flush,
// length clamping and reset-in-flush scenarios.
module tb_codeword_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cw_valid_i;
    logic        cw_ready_o;
    logic [20:0] cw_data_i;
    logic [5:0]  cw_length_i;
    logic        flush_i;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [31:0] word_data_o;
    logic [5:0]  word_nbits_o;
    logic        word_last_o;
    logic        overflow_err_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int cw_accepted  = 0;
    bit saw_last     = 1'b0;
    logic [31:0] wq_data[$];
    logic [5:0]  wq_nbits[$];

    always #5 clk_i = ~clk_i;

    codeword_packer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cw_valid_i     (cw_valid_i),
        .cw_ready_o     (cw_ready_o),
        .cw_data_i      (cw_data_i),
        .cw_length_i    (cw_length_i),
        .flush_i        (flush_i),
        .word_valid_o   (word_valid_o),
        .word_ready_i   (word_ready_i),
        .word_data_o    (word_data_o),
        .word_nbits_o   (word_nbits_o),
        .word_last_o    (word_last_o),
        .overflow_err_o (overflow_err_o)
    );

    // Record handshakes seen before the edge, then advance one cycle.
    task automatic step();
        if (cw_valid_i && cw_ready_o) cw_accepted++;
        if (word_valid_o && word_ready_i) begin
            wq_data.push_back(word_data_o);
            wq_nbits.push_back(word_nbits_o);
            if (word_last_o) saw_last = 1'b1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; cw_valid_i = 1'b0; flush_i = 1'b0; word_ready_i = 1'b1;
        cw_data_i = 21'd0; cw_length_i = 6'd0;
        step(); step();
        rst_i = 1'b0;
        wq_data.delete(); wq_nbits.delete();
        cw_accepted = 0; saw_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (word_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", word_valid_o); end
        tests_run++; if (overflow_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", overflow_err_o); end
        tests_run++; if (cw_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", cw_ready_o); end
        tests_run++; if (word_nbits_o !== 6'd0) begin tests_failed++; $display("FAIL reset_nbits: got %0d want 0", word_nbits_o); end
        tests_run++; if (word_data_o !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", word_data_o); end
    endtask

    task automatic test_pack_basic();
        do_reset();
        cw_valid_i = 1'b1; cw_length_i = 6'd14; cw_data_i = 21'h03FF4; step();
        cw_length_i = 6'd20; cw_data_i = 21'h0FFFEC; step();
        cw_valid_i = 1'b0; step();
        tests_run++; if (word_valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1", word_valid_o); end
        tests_run++; if (word_data_o !== 32'hFFD3FFFB) begin tests_failed++; $display("FAIL basic_data: got %h want FFD3FFFB", word_data_o); end
        tests_run++; if (word_nbits_o !== 6'd32) begin tests_failed++; $display("FAIL basic_nbits: got %0d want 32", word_nbits_o); end
        tests_run++; if (word_last_o !== 1'b0) begin tests_failed++; $display("FAIL basic_last: got %b want 0", word_last_o); end
        flush_i = 1'b1; step(); flush_i = 1'b0;
        tests_run++; if (word_valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_gap: got %b want 0", word_valid_o); end
        step();
        tests_run++; if ({word_valid_o, word_data_o, word_nbits_o, word_last_o} !== {1'b1, 32'h0, 6'd2, 1'b1})
            begin tests_failed++; $display("FAIL basic_flush: got v%b %h n%0d l%b want v1 00000000 n2 l1", word_valid_o, word_data_o, word_nbits_o, word_last_o); end
        step();
        tests_run++; if (word_valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_drop: got %b want 0", word_valid_o); end
    endtask

    task automatic test_back_to_back();
        int total;
        int guard;
        logic [31:0] mask;
        do_reset();
        word_ready_i = 1'b0;
        cw_valid_i = 1'b1; cw_length_i = 6'd21; cw_data_i = 21'h1FFFFF;
        repeat (5) step();
        tests_run++; if (cw_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_ready: got %b want 0", cw_ready_o); end
        tests_run++; if (cw_accepted !== 4) begin tests_failed++; $display("FAIL bp_accepted: got %0d want 4", cw_accepted); end
        repeat (3) step();
        tests_run++; if ({word_valid_o, word_data_o} !== {1'b1, 32'hFFFFFFFF})
            begin tests_failed++; $display("FAIL bp_hold: got v%b %h want v1 FFFFFFFF", word_valid_o, word_data_o); end
        tests_run++; if (cw_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_hold: got %b want 0", cw_ready_o); end
        word_ready_i = 1'b1;
        for (int n = 0; n < 20 && cw_accepted < 6; n++) step();
        cw_valid_i = 1'b0;
        flush_i = 1'b1; step(); flush_i = 1'b0;
        guard = 0;
        while (!saw_last && guard < 60) begin step(); guard++; end
        tests_run++; if (!saw_last) begin tests_failed++; $display("FAIL bp_timeout: got no last word want last within 60 cycles"); end
        total = 0;
        for (int i = 0; i < wq_data.size(); i++) begin
            total += int'(wq_nbits[i]);
            mask = ~(32'hFFFFFFFF >> wq_nbits[i]);
            tests_run++; if (wq_data[i] !== mask) begin tests_failed++; $display("FAIL bp_word%0d: got %h want %h", i, wq_data[i], mask); end
        end
        tests_run++; if (total !== 126) begin tests_failed++; $display("FAIL bp_bits: got %0d want 126", total); end
        tests_run++; if (wq_data.size() !== 4) begin tests_failed++; $display("FAIL bp_words: got %0d want 4", wq_data.size()); end
    endtask

    task automatic test_flush_with_cw();
        do_reset();
        cw_valid_i = 1'b1; cw_length_i = 6'd3; cw_data_i = 21'h5; flush_i = 1'b1;
        step();
        cw_valid_i = 1'b0; flush_i = 1'b0;
        tests_run++; if (cw_ready_o !== 1'b0) begin tests_failed++; $display("FAIL fcw_ready: got %b want 0", cw_ready_o); end
        step();
        tests_run++; if ({word_valid_o, word_data_o, word_nbits_o, word_last_o} !== {1'b1, 32'hA0000000, 6'd3, 1'b1})
            begin tests_failed++; $display("FAIL fcw_word: got v%b %h n%0d l%b want v1 A0000000 n3 l1", word_valid_o, word_data_o, word_nbits_o, word_last_o); end
    endtask

    task automatic test_length_edges();
        do_reset();
        cw_valid_i = 1'b1; cw_length_i = 6'd0; cw_data_i = 21'h1FFFFF; step();
        tests_run++; if (overflow_err_o !== 1'b0) begin tests_failed++; $display("FAIL len0_ovf: got %b want 0", overflow_err_o); end
        cw_length_i = 6'd25; step();
        cw_valid_i = 1'b0;
        tests_run++; if (overflow_err_o !== 1'b1) begin tests_failed++; $display("FAIL len25_ovf: got %b want 1", overflow_err_o); end
        flush_i = 1'b1; step(); flush_i = 1'b0; step();
        tests_run++; if ({word_valid_o, word_data_o, word_nbits_o, word_last_o} !== {1'b1, 32'hFFFFF800, 6'd21, 1'b1})
            begin tests_failed++; $display("FAIL len_clamp: got v%b %h n%0d l%b want v1 FFFFF800 n21 l1", word_valid_o, word_data_o, word_nbits_o, word_last_o); end
        repeat (3) step();
        tests_run++; if (overflow_err_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow_err_o); end
        do_reset();
        tests_run++; if (overflow_err_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b want 0", overflow_err_o); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        word_ready_i = 1'b0;
        cw_valid_i = 1'b1; cw_length_i = 6'd21; cw_data_i = 21'h1FFFFF;
        step(); step();
        cw_valid_i = 1'b0; flush_i = 1'b1; step(); flush_i = 1'b0;
        tests_run++; if ({word_valid_o, cw_ready_o} !== 2'b10) begin tests_failed++; $display("FAIL rif_pre: got v%b r%b want v1 r0", word_valid_o, cw_ready_o); end
        rst_i = 1'b1; step(); rst_i = 1'b0;
        tests_run++; if ({word_valid_o, cw_ready_o, word_last_o} !== 3'b010) begin tests_failed++; $display("FAIL rif_post: got v%b r%b l%b want v0 r1 l0", word_valid_o, cw_ready_o, word_last_o); end
        word_ready_i = 1'b1; flush_i = 1'b1; step(); flush_i = 1'b0; step();
        tests_run++; if ({word_valid_o, word_data_o, word_nbits_o, word_last_o} !== {1'b1, 32'h0, 6'd0, 1'b1})
            begin tests_failed++; $display("FAIL rif_empty_flush: got v%b %h n%0d l%b want v1 00000000 n0 l1", word_valid_o, word_data_o, word_nbits_o, word_last_o); end
    endtask

    initial begin
        test_reset();
        test_pack_basic();
        test_back_to_back();
        test_flush_with_cw();
        test_length_edges();
        test_reset_in_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
